// File: rtl/miriscv_gpr_pkg.sv
// GPR-side shared types: data/index widths and the writeback queue entry.
package miriscv_gpr_pkg;

   localparam int XLEN           = 32;
   localparam int GPR_ADDR_WIDTH = 5;

   // One long-latency result waiting for a free GPR write slot
   typedef struct packed {
      logic [GPR_ADDR_WIDTH-1:0] rd;
      logic [XLEN-1:0]           data;
   } wb_entry_t;

endpackage

// File: rtl/miriscv_wb_fifo.sv
// Small synchronous FIFO of writeback entries with a look-ahead head so a
// result pushed at one edge can be written to the GPR in the very next cycle.
module miriscv_wb_fifo
   import miriscv_gpr_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      push,
   input  wb_entry_t push_entry,
   input  logic      pop,
   output wb_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);

   wb_entry_t     mem_reg [DEPTH];
   logic [AW:0]   wr_ptr_reg, wr_ptr_next;
   logic [AW:0]   rd_ptr_reg, rd_ptr_next;

   // Pointers carry one wrap bit so full and empty are distinguishable
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      if (push) wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
   end

   // Pointer registers; reset discards any queued entries
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   // Storage needs no reset; validity is tracked by the pointers alone
   always_ff @(posedge clk_i) begin
      if (push) mem_reg[wr_ptr_reg[AW-1:0]] <= push_entry;
   end

   assign head  = mem_reg[rd_ptr_reg[AW-1:0]];
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

   a_no_overflow:  assert property (@(posedge clk_i) disable iff (rst_i) push |-> !full);
   a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) pop |-> !empty);

endmodule

// File: rtl/miriscv_gpr_wb_arb.sv
// Writeback arbiter in front of the single GPR write port. Pipeline writes
// always win; long-latency results wait in a short queue and drain in
// pipeline-idle cycles. A pending bitmap over rd drives the decode hazard.
module miriscv_gpr_wb_arb
   import miriscv_gpr_pkg::*;
#(
   parameter int LQ_DEPTH        = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      pipe_wr_en_i,
   input  logic [GPR_ADDR_WIDTH-1:0] pipe_wr_addr_i,
   input  logic [XLEN-1:0]           pipe_wr_data_i,
   input  logic                      iss_ll_valid_i,
   input  logic [GPR_ADDR_WIDTH-1:0] iss_ll_rd_i,
   output logic                      iss_ll_ready_o,
   input  logic [GPR_ADDR_WIDTH-1:0] dec_rs1_i,
   input  logic [GPR_ADDR_WIDTH-1:0] dec_rs2_i,
   input  logic [GPR_ADDR_WIDTH-1:0] dec_rd_i,
   output logic                      hazard_o,
   input  logic                      ll_valid_i,
   input  logic [GPR_ADDR_WIDTH-1:0] ll_rd_i,
   input  logic [XLEN-1:0]           ll_data_i,
   output logic                      ll_ready_o,
   output logic                      gpr_wr_en_o,
   output logic [GPR_ADDR_WIDTH-1:0] gpr_wr_addr_o,
   output logic [XLEN-1:0]           gpr_wr_data_o
);

   localparam int NREGS = 2**GPR_ADDR_WIDTH;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   wb_entry_t        fifo_head, fifo_entry;
   logic             issue_fire;
   logic [NREGS-1:0] pending_reg, pending_next;
   logic [CNT_W-1:0] outstanding_reg, outstanding_next;

   assign fifo_entry = '{rd: ll_rd_i, data: ll_data_i};
   assign ll_ready_o = !fifo_full;
   assign fifo_push  = ll_valid_i && !fifo_full;
   assign fifo_pop   = !pipe_wr_en_i && !fifo_empty;

   miriscv_wb_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push       (fifo_push),
      .push_entry (fifo_entry),
      .pop        (fifo_pop),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   assign iss_ll_ready_o = (outstanding_reg < CNT_W'(MAX_OUTSTANDING));
   assign issue_fire     = iss_ll_valid_i && iss_ll_ready_o;

   // x0 is never tracked; for other bits a new issue outranks a drain
   assign pending_next[0] = 1'b0;
   for (genvar gi = 1; gi < NREGS; gi++) begin : g_pending
      assign pending_next[gi] =
         (issue_fire && iss_ll_rd_i == GPR_ADDR_WIDTH'(gi)) ? 1'b1 :
         (fifo_pop && fifo_head.rd == GPR_ADDR_WIDTH'(gi))  ? 1'b0 :
         pending_reg[gi];
   end

   // Outstanding count: issue adds one, drain removes one, both cancel
   always_comb begin
      outstanding_next = outstanding_reg;
      if (issue_fire && !fifo_pop)
         outstanding_next = outstanding_reg + CNT_W'(1);
      else if (!issue_fire && fifo_pop)
         outstanding_next = outstanding_reg - CNT_W'(1);
   end

   // Scoreboard state registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pending_reg     <= '0;
         outstanding_reg <= '0;
      end else begin
         pending_reg     <= pending_next;
         outstanding_reg <= outstanding_next;
      end
   end

   assign hazard_o = pending_reg[dec_rs1_i] | pending_reg[dec_rs2_i] | pending_reg[dec_rd_i];

   // Write-port mux: pipeline first, queue head otherwise; rd=0 heads drain silently
   always_comb begin
      gpr_wr_en_o   = 1'b0;
      gpr_wr_addr_o = '0;
      gpr_wr_data_o = '0;
      if (pipe_wr_en_i) begin
         gpr_wr_en_o   = 1'b1;
         gpr_wr_addr_o = pipe_wr_addr_i;
         gpr_wr_data_o = pipe_wr_data_i;
      end else if (!fifo_empty) begin
         gpr_wr_en_o   = (fifo_head.rd != '0);
         gpr_wr_addr_o = fifo_head.rd;
         gpr_wr_data_o = fifo_head.data;
      end
   end

   // Upstream protocol rules; violating them corrupts the scoreboard
   a_pipe_not_pending: assert property (@(posedge clk_i) disable iff (rst_i)
      pipe_wr_en_i |-> !pending_reg[pipe_wr_addr_i]);
   a_result_expected: assert property (@(posedge clk_i) disable iff (rst_i)
      fifo_push |-> (outstanding_reg != '0));
   a_no_issue_on_hazard: assert property (@(posedge clk_i) disable iff (rst_i)
      iss_ll_valid_i |-> !hazard_o);

endmodule
